// File: rtl/seq_lock_pkg.sv
// Shared types and sizing helpers for the seq_lock serial combination lock.
// Imported by the top level and by the shared hold timer.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'b00,
    ST_OPEN    = 2'b01,
    ST_LOCKOUT = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  // Width of the shared hold timer: enough for max(open, lockout) - 1, never below 1 bit.
  function automatic int timer_width(input int open_cyc, input int lockout_cyc);
    int longest;
    longest = (open_cyc > lockout_cyc) ? open_cyc : lockout_cyc;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with a zero flag; one instance times both the open
// window and the lockout window of seq_lock. Updates on the falling clock edge.
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk) begin
    if (!clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_lock.sv
// Serial combination lock: framed CODE_W-bit attempts, runtime code load,
// consecutive-failure counting and timed lockout. All state moves on negedge clk.
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int                CODE_W      = 6,
  parameter logic [CODE_W-1:0] RESET_CODE  = 6'b101100,
  parameter int                MAX_FAIL    = 3,
  parameter int                OPEN_CYC    = 4,
  parameter int                LOCKOUT_CYC = 16
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          b_in,
  input  logic                          b_valid,
  input  logic                          load,
  input  logic [CODE_W-1:0]             code_in,
  output logic                          unlock,
  output logic                          locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic                          match_err
);

  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int BIT_W   = $clog2(CODE_W);
  localparam int TIMER_W = timer_width(OPEN_CYC, LOCKOUT_CYC);

  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(CODE_W - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT = FAIL_W'(MAX_FAIL);
  localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(OPEN_CYC - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCKOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   sreg_q, sreg_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                unlock_q, unlock_d;
  logic                locked_out_q, locked_out_d;
  logic                match_err_q, match_err_d;

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_load_val;
  logic                tmr_dec;
  logic                tmr_zero;

  logic [CODE_W-1:0]   attempt;
  logic [FAIL_W-1:0]   fail_inc;

  // The attempt as it stands once the current bit is shifted in.
  assign attempt  = {sreg_q[CODE_W-2:0], b_in};
  assign fail_inc = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + 1'b1;

  hold_timer #(
    .W(TIMER_W)
  ) u_hold_timer (
    .clk      (clk),
    .clear    (clear),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    code_d       = code_q;
    fail_d       = fail_q;
    match_err_d  = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        // A load restarts the frame and swallows any bit offered alongside it.
        if (load) begin
          code_d    = code_in;
          bit_cnt_d = '0;
        end else if (b_valid) begin
          sreg_d = attempt;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (attempt == code_q) begin
              state_d      = ST_OPEN;
              fail_d       = '0;
              tmr_load     = 1'b1;
              tmr_load_val = OPEN_LOAD;
            end else begin
              match_err_d = 1'b1;
              fail_d      = fail_inc;
              if (fail_inc == FAIL_LIMIT) begin
                state_d      = ST_LOCKOUT;
                tmr_load     = 1'b1;
                tmr_load_val = LOCK_LOAD;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_OPEN: begin
        if (tmr_zero) begin
          state_d = ST_COLLECT;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_LOCKOUT: begin
        fail_d = FAIL_LIMIT;
        if (tmr_zero) begin
          state_d = ST_COLLECT;
          fail_d  = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d   = ST_COLLECT;
        bit_cnt_d = '0;
      end
    endcase

    // Outputs are registered copies of where the FSM is heading.
    unlock_d     = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(negedge clk) begin
    if (!clear) begin
      state_q      <= ST_COLLECT;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      // NOTE: the code register is architectural state, so it is reset to a known code rather than left undefined.
      code_q       <= RESET_CODE;
      fail_q       <= '0;
      unlock_q     <= 1'b0;
      locked_out_q <= 1'b0;
      match_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      code_q       <= code_d;
      fail_q       <= fail_d;
      unlock_q     <= unlock_d;
      locked_out_q <= locked_out_d;
      match_err_q  <= match_err_d;
    end
  end

  assign unlock     = unlock_q;
  assign locked_out = locked_out_q;
  assign fail_cnt   = fail_q;
  assign match_err  = match_err_q;

endmodule
